// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer: drains memory traffic before writes,
// strobes the TLB once per op and owns the CP0 Random register.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  output logic             op_done,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             stall_fetch,
  output logic             tlbp,
  output logic             tlbwi,
  output logic             tlbwr,
  input  logic             miss_probe,
  input  logic [IDX_W:0]   matched_index_probe,
  output logic             probe_wb,
  output logic             probe_p,
  output logic [IDX_W-1:0] probe_idx,
  output logic             tlbr_wb,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] cp0_random
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ISSUE,
    FINISH
  } state_t;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [IDX_W-1:0] RND_MAX =
    IDX_W'(TLB_ENTRIES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_q;
  logic [1:0] op_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_TLBP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Writes must drain; flush only cancels before the strobe
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          op_d    = op_type;
          state_d = op_type[1] ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        if (flush)
          state_d = IDLE;
        else if (!mem_busy)
          state_d = ISSUE;
      end
      ISSUE:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_issue;
  logic in_fin;

  assign in_issue = (state_q == ISSUE);
  assign in_fin   = (state_q == FINISH);

  assign op_ready    = (state_q == IDLE);
  assign op_done     = in_fin;
  assign stall_fetch = op_q[1] && (state_q != IDLE);

  assign tlbp  = in_issue && (op_q == OP_TLBP);
  assign tlbwi = in_issue && (op_q == OP_TLBWI);
  assign tlbwr = in_issue && (op_q == OP_TLBWR);

  assign probe_wb  = in_fin && (op_q == OP_TLBP);
  assign tlbr_wb   = in_fin && (op_q == OP_TLBR);
  assign probe_p   = probe_wb && miss_probe;
  assign probe_idx = (probe_wb && !miss_probe)
                   ? matched_index_probe[IDX_W-1:0]
                   : '0;

  logic unused_hi;
  assign unused_hi = matched_index_probe[IDX_W];

  // Counts down toward wired; wired >= max pins it at max
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cp0_random <= RND_MAX;
    else if (wired_we || (cp0_random <= wired))
      cp0_random <= RND_MAX;
    else
      cp0_random <= cp0_random - 1'b1;
  end

endmodule
